// File: rtl/rob_buffer.sv
// Reorder buffer: dual in-order tag allocation, CDB result capture, operand lookup
// and dual in-order retirement feeding the architectural register file.
module rob_buffer #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned WRITE_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             dispatch_valid,
  input  logic [1:0]             dispatch_regf_we,
  input  logic [4:0]             dispatch_rd_s [2],
  output logic                   dispatch_ready,
  output logic [INDEX_WIDTH-1:0] alloc_id [2],
  input  logic [WRITE_PORTS-1:0] cdb_valid,
  input  logic [INDEX_WIDTH-1:0] cdb_rob_id [WRITE_PORTS],
  input  logic [31:0]            cdb_rd_v [WRITE_PORTS],
  input  logic [INDEX_WIDTH-1:0] rob1_s [2],
  input  logic [INDEX_WIDTH-1:0] rob2_s [2],
  output logic [31:0]            rob1_v [2],
  output logic [31:0]            rob2_v [2],
  output logic [1:0]             rob1_r,
  output logic [1:0]             rob2_r,
  output logic [INDEX_WIDTH-1:0] head_id,
  output logic [1:0]             commit_valid,
  output logic [1:0]             commit_regf_we,
  output logic [4:0]             commit_rd_s [2],
  output logic [31:0]            commit_rd_v [2]
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned CW    = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH-1:0]       ent_done;
  logic [DEPTH-1:0]       ent_we;
  logic [4:0]             ent_rd [DEPTH];
  logic [31:0]            ent_val [DEPTH];

  logic [INDEX_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0] tail;
  logic [INDEX_WIDTH-1:0] head_nx;
  logic [CW-1:0]          count;
  logic [1:0]             alloc_fire;
  logic [1:0]             n_alloc;
  logic [1:0]             n_ret;

  // Allocation: valid lanes are compacted so the first valid lane always takes tail.
  always_comb begin
    dispatch_ready = (count <= READY_MAX);
    alloc_id[0]    = tail;
    alloc_id[1]    = dispatch_valid[0] ? tail + INDEX_WIDTH'(1) : tail;
    alloc_fire     = (dispatch_ready && !flush) ? dispatch_valid : '0;
    n_alloc        = {1'b0, alloc_fire[0]} + {1'b0, alloc_fire[1]};
  end

  // Retirement: slot 1 only ever follows slot 0, so retirement stays in program order.
  always_comb begin
    head_nx         = head + INDEX_WIDTH'(1);
    head_id         = head;
    commit_valid[0] = ent_valid[head] & ent_done[head];
    commit_valid[1] = commit_valid[0] & ent_valid[head_nx] & ent_done[head_nx];
    commit_regf_we  = commit_valid & {ent_we[head_nx], ent_we[head]};
    commit_rd_s[0]  = commit_valid[0] ? ent_rd[head]     : '0;
    commit_rd_s[1]  = commit_valid[1] ? ent_rd[head_nx]  : '0;
    commit_rd_v[0]  = commit_valid[0] ? ent_val[head]    : '0;
    commit_rd_v[1]  = commit_valid[1] ? ent_val[head_nx] : '0;
    n_ret           = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
  end

  // Operand lookup reads registered state only; same-cycle CDB bypass is the consumer's job.
  always_comb begin
    rob1_r = '0;
    rob2_r = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      rob1_r[k] = ent_valid[rob1_s[k]] & ent_done[rob1_s[k]];
      rob2_r[k] = ent_valid[rob2_s[k]] & ent_done[rob2_s[k]];
      rob1_v[k] = ent_val[rob1_s[k]];
      rob2_v[k] = ent_val[rob2_s[k]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_done  <= '0;
      ent_we    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd[i]  <= '0;
        ent_val[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      // Commits shown this cycle are still taken by the register file; everything else is dropped.
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        if (cdb_valid[p] && ent_valid[cdb_rob_id[p]]) begin
          ent_done[cdb_rob_id[p]] <= 1'b1;
          ent_val[cdb_rob_id[p]]  <= cdb_rd_v[p];
        end
      end
      for (int unsigned l = 0; l < 2; l++) begin
        if (alloc_fire[l]) begin
          ent_valid[alloc_id[l]] <= 1'b1;
          ent_done[alloc_id[l]]  <= 1'b0;
          ent_we[alloc_id[l]]    <= dispatch_regf_we[l];
          ent_rd[alloc_id[l]]    <= dispatch_rd_s[l];
          ent_val[alloc_id[l]]   <= '0;
        end
      end
      if (commit_valid[0]) ent_valid[head]    <= 1'b0;
      if (commit_valid[1]) ent_valid[head_nx] <= 1'b0;
      head  <= head + INDEX_WIDTH'(n_ret);
      tail  <= tail + INDEX_WIDTH'(n_alloc);
      count <= count + CW'(n_alloc) - CW'(n_ret);
    end
  end

endmodule
